// File: rtl/ycbcr_thresh_ctrl.sv
// Push-button configuration controller for the YCbCr skin-threshold stage.
// Debounced keys edit a shadow threshold bank that is committed to the outputs at frame start.
module ycbcr_thresh_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_dec,
   input  logic       key_inc,
   input  logic       key_sel,
   input  logic       frame_start,
   output logic [7:0] y_lo,
   output logic [7:0] y_hi,
   output logic [7:0] cb_lo,
   output logic [7:0] cb_hi,
   output logic [7:0] cr_lo,
   output logic [7:0] cr_hi,
   output logic [2:0] choice_led,
   output logic       cfg_pending,
   output logic [3:0] dbg_state_o
);

   typedef enum logic [1:0] {IDLE, WAIT, RPT} rpt_state_e;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [7:0] RST_VAL [6] = '{8'd50, 8'd255, 8'd77, 8'd132, 8'd135, 8'd173};

   // Key bit order everywhere: 0 = dec, 1 = inc, 2 = sel
   logic [2:0]       keys;
   logic [2:0]       sync1_q, sync2_q, deb_q, deb_prev_q, press;
   logic [CNT_W-1:0] deb_cnt_q [3];

   rpt_state_e       rpt_state_q [2];
   logic [CNT_W-1:0] rpt_cnt_q [2];
   logic [1:0]       step_q;

   logic [7:0] shadow_q [6];
   logic [7:0] shadow_d [6];
   logic [7:0] active_q [6];
   logic [2:0] choice_q, choice_d, partner;
   logic       pending_q, changed;
   logic [7:0] cur;

   assign keys  = {key_sel, key_inc, key_dec};
   assign press = deb_q & ~deb_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int k = 0; k < 3; k++) deb_cnt_q[k] <= '0;
      end else begin
         sync1_q    <= keys;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
               deb_cnt_q[k] <= '0;
            end else if (deb_cnt_q[k] == DEB_LAST) begin
               deb_q[k]     <= ~deb_q[k];
               deb_cnt_q[k] <= '0;
            end else begin
               deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Auto-repeat FSMs for dec (0) and inc (1); a released key aborts without a step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
         for (int k = 0; k < 2; k++) begin
            rpt_state_q[k] <= IDLE;
            rpt_cnt_q[k]   <= '0;
         end
      end else begin
         step_q <= '0;
         for (int k = 0; k < 2; k++) begin
            case (rpt_state_q[k])
               IDLE: begin
                  if (press[k]) begin
                     step_q[k]      <= 1'b1;
                     rpt_cnt_q[k]   <= '0;
                     rpt_state_q[k] <= WAIT;
                  end
               end
               WAIT: begin
                  if (!deb_q[k]) begin
                     rpt_state_q[k] <= IDLE;
                  end else if (rpt_cnt_q[k] == DLY_LAST) begin
                     step_q[k]      <= 1'b1;
                     rpt_cnt_q[k]   <= '0;
                     rpt_state_q[k] <= RPT;
                  end else begin
                     rpt_cnt_q[k] <= rpt_cnt_q[k] + 1'b1;
                  end
               end
               RPT: begin
                  if (!deb_q[k]) begin
                     rpt_state_q[k] <= IDLE;
                  end else if (rpt_cnt_q[k] == PER_LAST) begin
                     step_q[k]    <= 1'b1;
                     rpt_cnt_q[k] <= '0;
                  end else begin
                     rpt_cnt_q[k] <= rpt_cnt_q[k] + 1'b1;
                  end
               end
               default: rpt_state_q[k] <= IDLE;
            endcase
         end
      end
   end

   // Lo entries are even, hi entries odd, so the pair partner is index ^ 1
   always_comb begin
      shadow_d = shadow_q;
      changed  = 1'b0;
      partner  = choice_q ^ 3'd1;
      cur      = shadow_q[choice_q];
      if (step_q[1] && !step_q[0]) begin
         if (cur != 8'hFF && !(!choice_q[0] && cur == shadow_q[partner])) begin
            shadow_d[choice_q] = cur + 8'd1;
            changed            = 1'b1;
         end
      end else if (step_q[0] && !step_q[1]) begin
         if (cur != 8'h00 && !(choice_q[0] && cur == shadow_q[partner])) begin
            shadow_d[choice_q] = cur - 8'd1;
            changed            = 1'b1;
         end
      end
      choice_d = choice_q;
      if (press[2]) choice_d = (choice_q == 3'd5) ? 3'd0 : choice_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) begin
            shadow_q[i] <= RST_VAL[i];
            active_q[i] <= RST_VAL[i];
         end
         choice_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         choice_q <= choice_d;
         if (changed) pending_q <= 1'b1;
         else if (frame_start && pending_q) pending_q <= 1'b0;
         if (frame_start && pending_q) active_q <= shadow_q;
      end
   end

   assign y_lo        = active_q[0];
   assign y_hi        = active_q[1];
   assign cb_lo       = active_q[2];
   assign cb_hi       = active_q[3];
   assign cr_lo       = active_q[4];
   assign cr_hi       = active_q[5];
   assign choice_led  = choice_q;
   assign cfg_pending = pending_q;
   assign dbg_state_o = {rpt_state_q[1], rpt_state_q[0]};

endmodule
